mem_copy_dma: RTL
=================

Name: mem_copy_dma

Overview:
- Block-copy DMA engine directly upstream of the 8-bit data memory. It owns the memory's address, writeEn and writeData inputs.
- When idle, the CPU datapath's memory signals pass straight through to the memory.
- When started, it copies `len` bytes from `srcAddr` to `dstAddr` using the memory's combinational read port. It stalls the CPU for the duration and pulses `done` at the end.

Parameters:
- ADDR_W, 8, memory address width; addresses and lengths wrap modulo 2^ADDR_W.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- srcAddr  in  ADDR_W  source base address; latched on accepted start.
- dstAddr  in  ADDR_W  destination base address; latched on accepted start.
- len  in  ADDR_W  byte count; latched on accepted start; 0 = no transfer.
- cpuAddress  in  ADDR_W  CPU memory address (pass-through).
- cpuWriteEn  in  1  CPU write enable (pass-through).
- cpuWriteData  in  DATA_W  CPU write data (pass-through).
- memReadData  in  DATA_W  combinational read data from the data memory.
- memAddress  out  ADDR_W  to the data memory address input.
- memWriteEn  out  1  to the data memory writeEn input.
- memWriteData  out  DATA_W  to the data memory writeData input.
- busy  out  1  high while the DMA owns memory; the CPU must hold its PC.
- done  out  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, READ, WRITE, DONE.
- Reset (async, any state): state=IDLE; internal src/dst/count/buffer registers=0. Outputs: busy=0, done=0; mem* follow the CPU inputs (combinational mux).
- IDLE:
  - mem* = cpu*.
  - start=1 and len!=0: latch src, dst and count=len; go to READ.
  - start=1 and len=0: go to DONE; no memory access.
- READ:
  - memAddress=src, memWriteEn=0.
  - At the clock edge: buffer<=memReadData; go to WRITE.
- WRITE:
  - memAddress=dst, memWriteEn=1, memWriteData=buffer.
  - At the clock edge: src<=src+1, dst<=dst+1 (wrap 0xFF->0x00), count<=count-1.
  - Next state is DONE if count==1, else READ.
- DONE:
  - mem* = cpu*; done=1 for exactly this cycle; then IDLE.
- busy = 1 in READ and WRITE only. CPU writes are blocked while busy (memWriteEn driven by the DMA only).
- Latency: start accepted at edge 0 gives 2*len cycles of transfer; done is high in the cycle after the last WRITE. For len=0, done is high in the cycle immediately after start.
- Byte order is ascending. Overlapping regions with dst>src propagate already-copied bytes (memmove semantics not provided); the bench checks this exact behaviour.
- start while not IDLE is ignored. Inputs srcAddr/dstAddr/len may change freely after acceptance.
- Reset mid-transfer: abort immediately, no done pulse. Bytes already written remain unless the memory itself is reset by the same rst.

Optional Feature:
- Macro DMA_FILL_EN.
- Defined:
  - Extra inputs `fillMode` (1) and `fillValue` (DATA_W), latched on start.
  - With fillMode=1 the FSM skips READ: IDLE->WRITE directly, and each WRITE writes fillValue to dst.
  - This gives len cycles total; the src register is unused.
  - fillMode=0 behaves exactly as the copy mode above.
- Undefined: the ports do not exist; copy only.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3;
  - ADDR_W/DATA_W defaults, shared with the data memory.
- One natural sub-module: `dma_mem_mux`, the combinational CPU/DMA selector for memAddress/memWriteEn/memWriteData, selected by busy.
- The FSM and counters stay in the top module.

Test Plan:
- Idle pass-through: cpuAddress=0x10, cpuWriteEn=1, cpuWriteData=0xA5, no start -> mem[0x10]=0xA5, busy=0, done=0.
- Basic copy: mem[0x20..0x23]={1,2,3,4}; start with src=0x20, dst=0x80, len=4 -> busy high 8 cycles, done pulse in cycle 9, mem[0x80..0x83]={1,2,3,4}, source unchanged.
- Wrap and zero length: src=0xFE, dst=0x01, len=3 -> reads 0xFE,0xFF,0x00. Separately, len=0 -> done the cycle after start, no memWriteEn ever high.
- Overlap forward: mem[0x40..0x42]={7,8,9}; src=0x40, dst=0x41, len=2 -> mem[0x41]=7, mem[0x42]=7.
- Abort and ignore: start len=10, assert rst at cycle 5 -> state IDLE, busy=0, no done. Also a second start while busy -> ignored, original transfer completes unchanged.
- DMA_FILL_EN: fillMode=1, fillValue=0x3C, dst=0x50, len=5 -> mem[0x50..0x54]=0x3C, busy 5 cycles, done in cycle 6.

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// rtl/mem_copy_dma_pkg.sv - shared widths and FSM encoding for mem_copy_dma and the data memory.
package mem_copy_dma_pkg;

  localparam int DMA_ADDR_W = 8;
  localparam int DMA_DATA_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // The DMA owns the memory port only while moving bytes; DONE already hands it back.
  function automatic logic owns_bus(input logic [1:0] state);
    return (state == READ) || (state == WRITE);
  endfunction

endpackage

// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - DMA control, CPU pass-through and data memory signals.
// DMA_FILL_EN adds fillMode/fillValue.
interface mem_copy_dma_if
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) ();

  logic              start;
  logic [ADDR_W-1:0] srcAddr;
  logic [ADDR_W-1:0] dstAddr;
  logic [ADDR_W-1:0] len;
`ifdef DMA_FILL_EN
  logic              fillMode;
  logic [DATA_W-1:0] fillValue;
`endif
  logic [ADDR_W-1:0] cpuAddress;
  logic              cpuWriteEn;
  logic [DATA_W-1:0] cpuWriteData;
  logic [DATA_W-1:0] memReadData;
  logic [ADDR_W-1:0] memAddress;
  logic              memWriteEn;
  logic [DATA_W-1:0] memWriteData;
  logic              busy;
  logic              done;

  modport slave (
    input  start, srcAddr, dstAddr, len,
    input  cpuAddress, cpuWriteEn, cpuWriteData, memReadData,
    output memAddress, memWriteEn, memWriteData, busy, done
`ifdef DMA_FILL_EN
    , input fillMode, fillValue
`endif
  );

  modport master (
    output start, srcAddr, dstAddr, len,
    output cpuAddress, cpuWriteEn, cpuWriteData, memReadData,
    input  memAddress, memWriteEn, memWriteData, busy, done
`ifdef DMA_FILL_EN
    , output fillMode, fillValue
`endif
  );

endinterface

// File: rtl/mem_copy_dma_mux.sv
// rtl/mem_copy_dma_mux.sv - combinational CPU/DMA selector in front of the data memory port.
module dma_mem_mux
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              sel,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_write_en,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic              dma_write_en,
  input  logic [DATA_W-1:0] dma_write_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data
);

  // While the DMA is selected the CPU write enable is dropped entirely.
  assign mem_address    = sel ? dma_address    : cpu_address;
  assign mem_write_en   = sel ? dma_write_en   : cpu_write_en;
  assign mem_write_data = sel ? dma_write_data : cpu_write_data;

endmodule

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - block-copy DMA ahead of the data memory; stalls the CPU while it runs.
// Defining DMA_FILL_EN adds a fill mode that writes fillValue without reading.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input logic           clk,
  input logic           rst,
  mem_copy_dma_if.slave bus
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] buffer;
  logic [1:0]        first_state;
  logic [1:0]        loop_state;
  logic [DATA_W-1:0] dma_write_data;
  logic              busy;
  logic              accept;

  assign accept = (state == IDLE) && bus.start && (bus.len != '0);

`ifdef DMA_FILL_EN
  logic              fill_mode;
  logic [DATA_W-1:0] fill_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_mode  <= 1'b0;
      fill_value <= '0;
    end else if (accept) begin
      fill_mode  <= bus.fillMode;
      fill_value <= bus.fillValue;
    end
  end

  // Fill mode never reads, so it enters and stays in WRITE.
  assign first_state    = bus.fillMode ? WRITE : READ;
  assign loop_state     = fill_mode ? WRITE : READ;
  assign dma_write_data = fill_mode ? fill_value : buffer;
`else
  assign first_state    = READ;
  assign loop_state     = READ;
  assign dma_write_data = buffer;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      count  <= '0;
      buffer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            src   <= bus.srcAddr;
            dst   <= bus.dstAddr;
            count <= bus.len;
            state <= first_state;
          end else if (bus.start) begin
            state <= DONE;
          end
        end
        READ: begin
          buffer <= bus.memReadData;
          state  <= WRITE;
        end
        WRITE: begin
          src   <= src + ADDR_W'(1);
          dst   <= dst + ADDR_W'(1);
          count <= count - ADDR_W'(1);
          state <= (count == ADDR_W'(1)) ? DONE : loop_state;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = owns_bus(state);
  assign bus.busy = busy;
  assign bus.done = (state == DONE);

  dma_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel            (busy),
    .cpu_address    (bus.cpuAddress),
    .cpu_write_en   (bus.cpuWriteEn),
    .cpu_write_data (bus.cpuWriteData),
    .dma_address    ((state == WRITE) ? dst : src),
    .dma_write_en   (state == WRITE),
    .dma_write_data (dma_write_data),
    .mem_address    (bus.memAddress),
    .mem_write_en   (bus.memWriteEn),
    .mem_write_data (bus.memWriteData)
  );

endmodule
